// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the exec_ctrl block: opcodes, FSM encoding and
// instruction field positions.
package exec_ctrl_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_MUL = 3'b110,
    OP_MOD = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Field positions inside the 16-bit instruction word (LSB and width).
  localparam int OP_LSB      = 13;
  localparam int OP_FW       = 3;
  localparam int RD_LSB      = 10;
  localparam int RS1_LSB     = 7;
  localparam int IMM_SEL_BIT = 6;
  localparam int RS2_LSB     = 3;
  localparam int REG_FW      = 3;
  localparam int IMM_LSB     = 0;
  localparam int IMM_FW      = 6;

endpackage

// File: rtl/exec_ctrl_regfile.sv
// Eight-entry register file: two operand read ports, one debug read port,
// one synchronous write port. R0 is hard-wired to zero.
module regfile8x16 #(
  parameter int DW = 16,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RA-1:0] raddr1,
  input  logic [RA-1:0] raddr2,
  input  logic [RA-1:0] dbg_raddr,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] dbg_rdata,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  localparam int NREG = 1 << RA;

  logic [DW-1:0] mem [NREG];

  // NOTE: this array is reset because every register must read 0 after reset;
  // a plain RAM without reset would not meet that and would map better to SRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write value during the write cycle, so no bypass here.
  assign rdata1    = (raddr1    == '0) ? '0 : mem[raddr1];
  assign rdata2    = (raddr2    == '0) ? '0 : mem[raddr2];
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : mem[dbg_raddr];

endmodule

// File: rtl/exec_ctrl.sv
// Four-state (IDLE/READ/EXEC/WB) execution controller driving an external
// combinational ALU and writing results back to an 8-entry register file.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int RA = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [2:0]         alu_sel,
  input  logic [DW-1:0]      alu_result,
  output logic               wb_valid,
  output logic [RA-1:0]      wb_rd,
  output logic [DW-1:0]      wb_data,
  output logic               mod_zero,
  input  logic [RA-1:0]      dbg_raddr,
  output logic [DW-1:0]      dbg_rdata
);

  state_t state, state_nxt;

  logic [INSTR_W-1:0] ir;
  logic [DW-1:0]      op_a, op_b, res;
  logic [DW-1:0]      rdata1, rdata2;
  logic               accept;
  logic               div_by_zero;

  logic [REG_FW-1:0]  f_rd, f_rs1, f_rs2;
  logic               f_imm_sel;
  logic [IMM_FW-1:0]  f_imm;
  logic [OP_FW-1:0]   f_op;

  assign f_op      = ir[OP_LSB  +: OP_FW];
  assign f_rd      = ir[RD_LSB  +: REG_FW];
  assign f_rs1     = ir[RS1_LSB +: REG_FW];
  assign f_rs2     = ir[RS2_LSB +: REG_FW];
  assign f_imm_sel = ir[IMM_SEL_BIT];
  assign f_imm     = ir[IMM_LSB +: IMM_FW];

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign div_by_zero = (f_op == OP_MOD) && (op_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      mod_zero <= 1'b0;
    end else begin
      if (accept) ir <= instr;
      if (state == ST_READ) begin
        op_a <= rdata1;
        op_b <= f_imm_sel ? DW'(f_imm) : rdata2;
      end
      if (state == ST_EXEC) begin
        if (div_by_zero) begin
          res      <= '1;
          mod_zero <= 1'b1;
        end else begin
          res <= alu_result;
        end
      end
    end
  end

  // ALU inputs come only from registers, so they hold from EXEC through WB.
  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = f_op;

  assign wb_valid = (state == ST_WB);
  assign wb_rd    = RA'(f_rd);
  assign wb_data  = res;

  regfile8x16 #(.DW(DW), .RA(RA)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr1    (RA'(f_rs1)),
    .raddr2    (RA'(f_rs2)),
    .dbg_raddr (dbg_raddr),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .dbg_rdata (dbg_rdata),
    .we        (wb_valid),
    .waddr     (wb_rd),
    .wdata     (res)
  );

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random instructions against a register model.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  localparam int DW    = 16;
  localparam int RA    = 3;
  localparam int CLK_P = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [15:0]   instr = '0;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_sel;
  logic          wb_valid;
  logic [RA-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          mod_zero;
  logic [RA-1:0] dbg_raddr = '0;
  logic [DW-1:0] dbg_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #(CLK_P / 2) clk = ~clk;

  exec_ctrl #(.DW(DW), .RA(RA)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mod_zero    (mod_zero),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
  );

  // External ALU; mod-by-zero returns a junk value the controller must override.
  function automatic logic [15:0] alu_fn(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (s)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a << b;
      3'd5: r = a >> b;
      3'd6: r = a * b;
      default: r = (b == 16'd0) ? 16'h1234 : a % b;
    endcase
    return r;
  endfunction

  assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

  function automatic logic [15:0] enc_i(input logic [2:0] op, input int rd, input int rs1, input int imm);
    return {op, 3'(rd), 3'(rs1), 1'b1, 6'(imm)};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] op, input int rd, input int rs1, input int rs2);
    return {op, 3'(rd), 3'(rs1), 1'b0, 3'(rs2), 3'b000};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers w from a negedge until accepted; acc_t is the accepting posedge time.
  task automatic issue(input logic [15:0] w, input bit keep, output time acc_t);
    int guard = 0;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 32'(guard >= 16), 0);
    acc_t = $time + CLK_P / 2;
    if (!keep) begin
      @(negedge clk);
      instr_valid = 1'b0;
    end
  endtask

  // Waits for the writeback strobe; returns its edge time, fields and the
  // debug-port value of rd seen during that WB cycle.
  task automatic wait_wb(output time wb_t, output logic [RA-1:0] rd,
                         output logic [DW-1:0] data, output logic [DW-1:0] dbg_old);
    int guard = 0;
    while (!wb_valid && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    check("wb_timeout", 32'(guard >= 16), 0);
    wb_t      = $time + CLK_P / 2;
    rd        = wb_rd;
    data      = wb_data;
    dbg_raddr = wb_rd;
    #1;
    dbg_old = dbg_rdata;
    @(negedge clk);
    check("wb_one_cycle", 32'(wb_valid), 0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] w;
    logic [2:0]  rd;
    logic [15:0] data;
    logic        mz;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input string name, input logic [15:0] w, input int rd,
                         input logic [15:0] data, input logic mz);
    vec_t v;
    v.name = name;
    v.w    = w;
    v.rd   = 3'(rd);
    v.data = data;
    v.mz   = mz;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    time           t_acc, t_wb, t_acc2;
    logic [RA-1:0] g_rd;
    logic [DW-1:0] g_data, g_old;
    logic [15:0]   model_r [8];
    logic          model_mz;
    int            pulses;

    add_vec("seed_r1",   enc_i(OP_ADD, 1, 0, 5), 1, 16'd5,    1'b0);
    add_vec("add_r1r1",  enc_r(OP_ADD, 2, 1, 1), 2, 16'd10,   1'b0);
    add_vec("seed_r1_7", enc_i(OP_ADD, 1, 0, 7), 1, 16'd7,    1'b0);
    add_vec("mod_by_r0", enc_r(OP_MOD, 3, 1, 0), 3, 16'hFFFF, 1'b1);
    add_vec("seed_r4",   enc_i(OP_ADD, 4, 0, 3), 4, 16'd3,    1'b1);
    add_vec("sub_3_5",   enc_i(OP_SUB, 5, 4, 5), 5, 16'hFFFE, 1'b1);
    add_vec("seed_r6",   enc_i(OP_ADD, 6, 0, 1), 6, 16'd1,    1'b1);
    add_vec("shl_8",     enc_i(OP_SHL, 6, 6, 8), 6, 16'h0100, 1'b1);
    add_vec("mul_trunc", enc_r(OP_MUL, 7, 6, 6), 7, 16'h0000, 1'b1);
    add_vec("write_r0",  enc_i(OP_ADD, 0, 0, 9), 0, 16'd9,    1'b1);
    add_vec("shr_1",     enc_i(OP_SHR, 1, 2, 1), 1, 16'd5,    1'b1);
    add_vec("and_imm",   enc_i(OP_AND, 2, 2, 6), 2, 16'd2,    1'b1);
    add_vec("or_reg",    enc_r(OP_OR,  3, 3, 2), 3, 16'hFFFF, 1'b1);
    add_vec("mod_nz",    enc_i(OP_MOD, 4, 1, 3), 4, 16'd2,    1'b1);
    add_vec("sub_zero",  enc_r(OP_SUB, 5, 2, 4), 5, 16'd0,    1'b1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready",    32'(instr_ready), 1);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_mod_zero", 32'(mod_zero), 0);
    check("rst_alu_a",    32'(alu_a), 0);
    check("rst_alu_b",    32'(alu_b), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(instr_ready), 1);

    // Directed vector table.
    foreach (tbl[k]) begin
      issue(tbl[k].w, 1'b0, t_acc);
      wait_wb(t_wb, g_rd, g_data, g_old);
      check({tbl[k].name, "_latency"}, 32'((t_wb - t_acc) / CLK_P), 3);
      check({tbl[k].name, "_rd"},      32'(g_rd), 32'(tbl[k].rd));
      check({tbl[k].name, "_data"},    32'(g_data), 32'(tbl[k].data));
      check({tbl[k].name, "_modzero"}, 32'(mod_zero), 32'(tbl[k].mz));
      dbg_raddr = tbl[k].rd;
      #1;
      check({tbl[k].name, "_dbg_new"}, 32'(dbg_rdata), (tbl[k].rd == 0) ? 0 : 32'(tbl[k].data));
    end

    // Back-to-back with valid held high: R1=20, then R2=R1+R1.
    issue(enc_i(OP_ADD, 1, 0, 20), 1'b1, t_acc);
    issue(enc_r(OP_ADD, 2, 1, 1), 1'b0, t_acc2);
    check("b2b_spacing", 32'((t_acc2 - t_acc) / CLK_P), 4);
    wait_wb(t_wb, g_rd, g_data, g_old);
    check("b2b_rd",   32'(g_rd), 2);
    check("b2b_data", 32'(g_data), 40);

    // Reset pulsed during EXEC aborts the instruction.
    issue(enc_i(OP_ADD, 3, 0, 33), 1'b0, t_acc);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("abort_ready_in_rst", 32'(instr_ready), 1);
    check("abort_modzero",      32'(mod_zero), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (wb_valid) pulses++;
      @(negedge clk);
    end
    check("abort_no_wb",    32'(pulses), 0);
    check("abort_ready",    32'(instr_ready), 1);
    check("abort_alu_a",    32'(alu_a), 0);
    for (int a = 0; a < 8; a++) begin
      dbg_raddr = 3'(a);
      #1;
      check($sformatf("abort_r%0d", a), 32'(dbg_rdata), 0);
    end

    // Random instructions against an architectural model.
    foreach (model_r[i]) model_r[i] = '0;
    model_mz = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic [15:0] w, a, b, exp;
      int op, rd, rs1, rs2, imm, isel;
      w    = 16'($urandom);
      op   = (w >> 13) & 7;
      rd   = (w >> 10) & 7;
      rs1  = (w >> 7) & 7;
      isel = (w >> 6) & 1;
      rs2  = (w >> 3) & 7;
      imm  = w & 63;
      a    = model_r[rs1];
      b    = isel ? 16'(imm) : model_r[rs2];
      if (op == 7 && b == 0) begin
        exp      = 16'hFFFF;
        model_mz = 1'b1;
      end else begin
        exp = alu_fn(3'(op), a, b);
      end
      issue(w, 1'b0, t_acc);
      wait_wb(t_wb, g_rd, g_data, g_old);
      check("rnd_latency", 32'((t_wb - t_acc) / CLK_P), 3);
      check("rnd_rd",      32'(g_rd), 32'(rd));
      check("rnd_data",    32'(g_data), 32'(exp));
      check("rnd_dbg_old", 32'(g_old), 32'(model_r[rd]));
      check("rnd_modzero", 32'(mod_zero), 32'(model_mz));
      if (rd != 0) model_r[rd] = exp;
      dbg_raddr = 3'($urandom_range(0, 7));
      #1;
      check("rnd_dbg", 32'(dbg_rdata), 32'(model_r[dbg_raddr]));
    end

    do_reset();
    @(negedge clk);
    check("final_ready",   32'(instr_ready), 1);
    check("final_modzero", 32'(mod_zero), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter DW, default 16: datapath width; shall match ALU operand width.
REQ-002 Parameter RA, default 3: register-address width, giving 2**RA = 8 registers.
REQ-003 Port clk, input, 1: single clock; all state shall update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port instr_valid, input, 1: instruction offered.
REQ-006 Port instr_ready, output, 1: block can accept an instruction.
REQ-007 Port instr, input, 16: [15:13] op, [12:10] rd, [9:7] rs1, [6] imm_sel, [5:3] rs2, [5:0] imm6.
REQ-008 Port alu_a, output, DW: ALU operand A.
REQ-009 Port alu_b, output, DW: ALU operand B.
REQ-010 Port alu_sel, output, 3: ALU select (000 add, 001 sub, 010 and, 011 or, 100 shl, 101 shr, 110 mul, 111 mod).
REQ-011 Port alu_result, input, DW: combinational ALU output.
REQ-012 Port wb_valid, output, 1: one-cycle writeback strobe.
REQ-013 Port wb_rd, output, RA: destination of the writeback.
REQ-014 Port wb_data, output, DW: value written.
REQ-015 Port mod_zero, output, 1: sticky flag, set when a mod-by-zero is executed.
REQ-016 Port dbg_raddr, input, RA: debug read address.
REQ-017 Port dbg_rdata, output, DW: combinational register-file read of dbg_raddr.

Function
REQ-018 FSM states shall be IDLE, READ, EXEC, WB, with transitions IDLE->READ on instr_valid&&instr_ready, READ->EXEC, EXEC->WB, WB->IDLE, each unconditional.
REQ-019 instr_ready shall be 1 only in IDLE; the instruction shall be captured into an instruction register on the accepting edge.
REQ-020 READ shall latch opA=R[rs1] and opB=(imm_sel ? {10'b0,imm6} : R[rs2]) into operand registers.
REQ-021 alu_a, alu_b and alu_sel shall be driven only from the operand and instruction registers and shall be held stable from EXEC through WB.
REQ-022 EXEC shall capture alu_result into a result register, except when op=111 and opB=0, where it shall capture 16'hFFFF and set mod_zero.
REQ-023 WB shall write the result to R[rd], assert wb_valid for exactly one cycle, and present wb_rd/wb_data that cycle.
REQ-024 R0 shall read as 0 on every path; a write to rd=0 shall be discarded, while wb_valid still pulses with wb_data equal to the computed result.
REQ-025 Latency from the accept edge to the wb_valid cycle shall be 3 cycles; throughput shall be one instruction per 4 cycles.
REQ-026 Arithmetic shall be the ALU's, truncated to DW; the block shall not alter shift or multiply results.
REQ-027 rd equal to rs1/rs2 shall need no forwarding: the written value shall be visible to the next accepted instruction's READ.
REQ-028 instr_valid outside IDLE shall be ignored and shall not be consumed.
REQ-029 A dbg_raddr equal to the WB rd shall return the old value in the WB cycle and the new value afterwards.

Reset
REQ-030 While rst_n=0: state=IDLE; registers R0..R7, operand, result and instruction registers=0; wb_valid=0; mod_zero=0; instr_ready=1 one cycle after deassertion.
REQ-031 Reset asserted mid-instruction shall abort it with no register-file write and no wb_valid pulse.

Structure
REQ-032 A shared package shall hold the opcode constants (OP_ADD..OP_MOD), the FSM state encoding, and the instr field bit positions.
REQ-033 The register file shall be a sub-module named regfile8x16: two combinational read ports, one debug read port, and one synchronous write port, with the R0 rule inside it.

Verification
REQ-034 Scenario: seed R1=5 via imm-add, then add R2=R1+R1 -> wb_valid 3 cycles after accept, wb_rd=2, wb_data=10.
REQ-035 Scenario: R1=7, then mod R3=R1%R0 -> wb_data=16'hFFFF and mod_zero=1, held until reset.
REQ-036 Scenario: mul of 16'h0100 by 16'h0100 -> wb_data=0 (truncated); sub 3-5 -> 16'hFFFE.
REQ-037 Scenario: write rd=0 with value 9 -> wb_valid pulses, and dbg_rdata at address 0 stays 0.
REQ-038 Scenario: back-to-back valid held high for 2 instructions -> second accepted exactly 4 cycles after the first, and it reads the first's result.
REQ-039 Scenario: rst_n pulsed low during EXEC -> no wb_valid, all registers 0, instr_ready=1 after release.
